// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings and store/alignment helpers for the miniRV MEM/WB stage.
// Writeback selects, funct3 size codes and FSM state codes live here.
package mem_wb_stage_pkg;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_EXT  = 2'b01;
    localparam logic [1:0] WB_PC   = 2'b10;
    localparam logic [1:0] WB_DREM = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    // Access size comes from funct3[1:0]; unknown sizes behave as a word.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] alo);
        logic mis;
        case (funct3[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = alo[0];
            default: mis = (alo != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] funct3, input logic [1:0] alo);
        logic [3:0] strb;
        case (funct3[1:0])
            2'b00:   strb = 4'b0001 << alo;
            2'b01:   strb = 4'b0011 << alo;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] rd2);
        logic [31:0] data;
        case (funct3[1:0])
            2'b00:   data = {4{rd2[7:0]}};
            2'b01:   data = {2{rd2[15:0]}};
            default: data = rd2;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/mem_wb_stage_load_formatter.sv
// Purely combinational load-data formatter: selects the byte/half lane of the
// returned word and sign- or zero-extends it according to funct3.
module load_formatter
    import mem_wb_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection from the latched low address bits.
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Extension by access type; unrecognised codes return the whole word.
    always_comb begin
        data = rdata;
        case (funct3)
            F3_LB:   data = {{24{byte_s[7]}}, byte_s};
            F3_LH:   data = {{16{half_s[15]}}, half_s};
            F3_LBU:  data = {24'h000000, byte_s};
            F3_LHU:  data = {16'h0000, half_s};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage and MEM/WB pipeline register: runs loads/stores over a req/ack
// data-memory handshake with timeout abort, and registers the writeback bundle.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        mem_valid,
    input  logic        mem_rf_we,
    input  logic [4:0]  mem_wR,
    input  logic [1:0]  mem_rf_wsel,
    input  logic [31:0] mem_wD,
    input  logic [31:0] mem_rD2,
    input  logic        mem_is_load,
    input  logic        mem_is_store,
    input  logic [2:0]  mem_funct3,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_rf_we,
    output logic [4:0]  wb_wR,
    output logic [1:0]  wb_rf_wsel,
    output logic [31:0] wb_wD_in,
    output logic [31:0] wb_dram_in,
    output logic        misalign_err,
    output logic        bus_err
);

    localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 32'd1);

    state_e      state_r, state_s;
    logic [15:0] tcnt_r, tcnt_s;
    logic [2:0]  f3_r, f3_s;
    logic [1:0]  alo_r, alo_s;
    logic        acc_s, mis_s, abort_s;
    logic [31:0] ld_data_s;

    logic        dmem_req_s, dmem_we_s;
    logic [31:0] dmem_addr_s, dmem_wdata_s;
    logic [3:0]  dmem_wstrb_s;
    logic        wb_valid_s, wb_rf_we_s, misalign_s, bus_err_s;
    logic [4:0]  wb_wR_s;
    logic [1:0]  wb_rf_wsel_s;
    logic [31:0] wb_wD_in_s, wb_dram_in_s;

    assign acc_s   = mem_valid & (mem_is_load | mem_is_store);
    assign mis_s   = acc_s & is_misaligned(mem_funct3, mem_wD[1:0]);
    assign abort_s = (state_r == ST_REQ) & ~dmem_ack & (tcnt_r == TO_LAST);

    load_formatter u_load_formatter (
        .rdata   (dmem_rdata),
        .funct3  (f3_r),
        .addr_lo (alo_r),
        .data    (ld_data_s)
    );

    // State register.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (acc_s && !mis_s) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dmem_ack || abort_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_REQ;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output logic: stall plus next values of every registered output.
    always_comb begin
        mem_stall    = 1'b0;
        tcnt_s       = 16'd0;
        dmem_req_s   = dmem_req;
        dmem_we_s    = dmem_we;
        dmem_addr_s  = dmem_addr;
        dmem_wdata_s = dmem_wdata;
        dmem_wstrb_s = dmem_wstrb;
        f3_s         = f3_r;
        alo_s        = alo_r;
        wb_valid_s   = 1'b0;
        wb_rf_we_s   = 1'b0;
        wb_wR_s      = 5'd0;
        wb_rf_wsel_s = 2'b00;
        wb_wD_in_s   = 32'd0;
        wb_dram_in_s = 32'd0;
        misalign_s   = 1'b0;
        bus_err_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (acc_s && !mis_s) begin
                    mem_stall    = 1'b1;
                    dmem_req_s   = 1'b1;
                    dmem_we_s    = mem_is_store;
                    dmem_addr_s  = {mem_wD[31:2], 2'b00};
                    dmem_wdata_s = store_data(mem_funct3, mem_rD2);
                    dmem_wstrb_s = store_strb(mem_funct3, mem_wD[1:0]);
                    f3_s         = mem_funct3;
                    alo_s        = mem_wD[1:0];
                end else begin
                    wb_valid_s   = mem_valid;
                    wb_rf_we_s   = mem_rf_we & ~mis_s;
                    wb_wR_s      = mem_wR;
                    wb_rf_wsel_s = mem_rf_wsel;
                    wb_wD_in_s   = mem_wD;
                    misalign_s   = mis_s;
                end
            end
            ST_REQ: begin
                if (dmem_ack) begin
                    dmem_req_s   = 1'b0;
                    wb_valid_s   = mem_valid;
                    wb_rf_we_s   = mem_rf_we & ~mem_is_store;
                    wb_wR_s      = mem_wR;
                    wb_rf_wsel_s = mem_rf_wsel;
                    wb_wD_in_s   = mem_wD;
                    wb_dram_in_s = mem_is_load ? ld_data_s : 32'd0;
                end else if (abort_s) begin
                    // The aborted instruction retires without a register write.
                    dmem_req_s   = 1'b0;
                    bus_err_s    = 1'b1;
                    wb_valid_s   = 1'b1;
                    wb_wR_s      = mem_wR;
                    wb_rf_wsel_s = mem_rf_wsel;
                    wb_wD_in_s   = mem_wD;
                end else begin
                    mem_stall = 1'b1;
                    tcnt_s    = tcnt_r + 16'd1;
                end
            end
            default: begin
                mem_stall = 1'b0;
            end
        endcase
    end

    // Registered datapath: memory request fields, WB bundle and error pulses.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            tcnt_r       <= 16'd0;
            f3_r         <= 3'b000;
            alo_r        <= 2'b00;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= 32'd0;
            dmem_wdata   <= 32'd0;
            dmem_wstrb   <= 4'b0000;
            wb_valid     <= 1'b0;
            wb_rf_we     <= 1'b0;
            wb_wR        <= 5'd0;
            wb_rf_wsel   <= 2'b00;
            wb_wD_in     <= 32'd0;
            wb_dram_in   <= 32'd0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            tcnt_r       <= tcnt_s;
            f3_r         <= f3_s;
            alo_r        <= alo_s;
            dmem_req     <= dmem_req_s;
            dmem_we      <= dmem_we_s;
            dmem_addr    <= dmem_addr_s;
            dmem_wdata   <= dmem_wdata_s;
            dmem_wstrb   <= dmem_wstrb_s;
            wb_valid     <= wb_valid_s;
            wb_rf_we     <= wb_rf_we_s;
            wb_wR        <= wb_wR_s;
            wb_rf_wsel   <= wb_rf_wsel_s;
            wb_wD_in     <= wb_wD_in_s;
            wb_dram_in   <= wb_dram_in_s;
            misalign_err <= misalign_s;
            bus_err      <= bus_err_s;
        end
    end

endmodule
